// File: rtl/digit_tx_pkg.sv
`default_nettype none
// ============================================================================
// Package  : digit_tx_pkg
// Purpose  : FSM encoding and ASCII character map shared by digit_uart_tx.
// Revision : 1.0
// ============================================================================
package digit_tx_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CHAR = 3'd1,
        DOT  = 3'd2,
        GAP  = 3'd3,
        CR   = 3'd4,
        LF   = 3'd5
    } tx_state_t;

    localparam logic [7:0] ASCII_DOT = 8'h2E;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_A   = 8'h41;

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_0 + {4'h0, nib};
        end
        return ASCII_A + {4'h0, nib - 4'd10};
    endfunction

endpackage
`default_nettype wire

// File: rtl/digit_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : digit_uart_tx
// Purpose  : Snapshots the display digits and decimal-point mask on a send
//            request and streams them as ASCII over the UART byte port, most
//            significant digit first. Define DIGIT_UART_TX_CRLF_EN to append
//            CR LF to every frame.
// Revision : 1.0
// ============================================================================
module digit_uart_tx
    import digit_tx_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DIGIT_W    = 4
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                send,
    input  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  digits,
    input  logic [NUM_DIGITS-1:0]               flt_pt,
    input  logic                                txready,
    output logic [7:0]                          txdata,
    output logic                                txclk,
    output logic                                busy,
    output logic                                done
);

    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_DIGITS - 1);

    tx_state_t                            r_state, w_state;
    tx_state_t                            r_ret, w_ret;
    logic [c_IDX_W-1:0]                   r_idx, w_idx, w_idx_m1;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   r_digits, w_digits;
    logic [NUM_DIGITS-1:0]                r_flt, w_flt;
    logic [7:0]                           r_txdata, w_txdata;
    logic                                 r_done, w_done;
    logic                                 w_strobe;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= IDLE;
            r_ret    <= IDLE;
            r_idx    <= '0;
            r_digits <= '0;
            r_flt    <= '0;
            r_txdata <= 8'h00;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_ret    <= w_ret;
            r_idx    <= w_idx;
            r_digits <= w_digits;
            r_flt    <= w_flt;
            r_txdata <= w_txdata;
            r_done   <= w_done;
        end
    end

    assign w_idx_m1 = r_idx - c_IDX_W'(1);

    // Each byte is loaded into txdata on the edge that leaves the previous
    // state, then GAP gives it one settled cycle before the strobe state.
    always_comb begin
        w_state  = r_state;
        w_ret    = r_ret;
        w_idx    = r_idx;
        w_digits = r_digits;
        w_flt    = r_flt;
        w_txdata = r_txdata;
        w_done   = 1'b0;
        w_strobe = 1'b0;
        case (r_state)
            IDLE: begin
                if (send && !r_done) begin
                    w_digits = digits;
                    w_flt    = flt_pt;
                    w_idx    = c_LAST_IDX;
                    w_txdata = hex_to_ascii(digits[NUM_DIGITS-1]);
                    w_ret    = CHAR;
                    w_state  = GAP;
                end
            end
            GAP: begin
                w_state = r_ret;
            end
            CHAR, DOT: begin
                if (txready) begin
                    w_strobe = 1'b1;
                    if (r_state == CHAR && r_flt[r_idx]) begin
                        w_txdata = ASCII_DOT;
                        w_ret    = DOT;
                        w_state  = GAP;
                    end else if (r_idx != '0) begin
                        w_idx    = w_idx_m1;
                        w_txdata = hex_to_ascii(r_digits[w_idx_m1]);
                        w_ret    = CHAR;
                        w_state  = GAP;
                    end else begin
`ifdef DIGIT_UART_TX_CRLF_EN
                        w_txdata = ASCII_CR;
                        w_ret    = CR;
                        w_state  = GAP;
`else
                        w_state  = IDLE;
                        w_done   = 1'b1;
`endif
                    end
                end
            end
`ifdef DIGIT_UART_TX_CRLF_EN
            CR: begin
                if (txready) begin
                    w_strobe = 1'b1;
                    w_txdata = ASCII_LF;
                    w_ret    = LF;
                    w_state  = GAP;
                end
            end
            LF: begin
                if (txready) begin
                    w_strobe = 1'b1;
                    w_state  = IDLE;
                    w_done   = 1'b1;
                end
            end
`endif
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign txdata = r_txdata;
    assign txclk  = w_strobe;
    assign busy   = (r_state != IDLE);
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_digit_uart_tx.sv
`default_nettype none
// Bench for digit_uart_tx: scoreboarded byte stream plus stall, abort and
// ignored-send scenarios.
module tb_digit_uart_tx;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        send = 1'b0;
    logic        txready = 1'b1;
    logic [31:0] digits = 32'h0;
    logic [7:0]  flt_pt = 8'h0;
    logic [7:0]  txdata;
    logic        txclk, busy, done;

    int          checks = 0;
    int          errors = 0;
    int          n_strobes = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;
    logic        prev_txclk = 1'b0;

    digit_uart_tx #(.NUM_DIGITS(8), .DIGIT_W(4)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .send    (send),
        .digits  (digits),
        .flt_pt  (flt_pt),
        .txready (txready),
        .txdata  (txdata),
        .txclk   (txclk),
        .busy    (busy),
        .done    (done)
    );

    always #5 CLK = ~CLK;

    // Byte monitor: every strobe must consume the head of the scoreboard.
    always @(negedge CLK) begin
        if (!RST && txclk === 1'b1) begin
            n_strobes++;
            checks++;
            assert (txready === 1'b1 && prev_txclk === 1'b0) else begin
                errors++;
                $error("FAIL strobe_handshake: txready=%b prev_txclk=%b, required 1/0", txready, prev_txclk);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL unexpected_byte: observed %h, expected no strobe", txdata);
            end else begin
                mon_exp = exp_q.pop_front();
                assert (txdata === mon_exp) else begin
                    errors++;
                    $error("FAIL byte: observed %h, expected %h", txdata, mon_exp);
                end
            end
        end
        prev_txclk = txclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [31:0] d, input logic [7:0] f);
        logic [3:0] n;
        for (int i = 7; i >= 0; i--) begin
            n = d[i*4 +: 4];
            exp_q.push_back((n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n}));
            if (f[i]) exp_q.push_back(8'h2E);
        end
`ifdef DIGIT_UART_TX_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic send_frame(input logic [31:0] d, input logic [7:0] f);
        @(posedge CLK); #1;
        digits = d;
        flt_pt = f;
        send   = 1'b1;
        push_frame(d, f);
        @(posedge CLK); #1;
        send = 1'b0;
        check("busy_after_accept", {31'h0, busy}, 32'd1);
        check("no_strobe_first_cycle", {31'h0, txclk}, 32'd0);
    endtask

    task automatic wait_strobes(input int target);
        bit reached = 1'b0;
        for (int c = 0; c < 300 && !reached; c++) begin
            @(negedge CLK); #1;
            if (n_strobes >= target) reached = 1'b1;
        end
        checks++;
        assert (reached) else begin
            errors++;
            $error("FAIL strobe_timeout: observed %0d strobes, expected %0d", n_strobes, target);
        end
    endtask

    task automatic wait_frame_end(input bit poke);
        bit found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge CLK);
            if (done === 1'b1) found = 1'b1;
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL frame_timeout: observed done=%b, expected 1 within 400 cycles", done);
        end
        if (found) begin
            check("busy_in_done", {31'h0, busy}, 32'd0);
            check("queue_drained", exp_q.size(), 32'd0);
            if (poke) send = 1'b1;
            @(posedge CLK); #1;
            send = 1'b0;
            check("done_one_cycle", {31'h0, done}, 32'd0);
        end
    endtask

    initial begin
        int         base;
        logic [7:0] hold;

        // Reset state
        #12;
        check("rst_txdata", {24'h0, txdata}, 32'h0);
        check("rst_txclk", {31'h0, txclk}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // Plain hex digits, no dots
        send_frame(32'h1234_5678, 8'h00);
        wait_frame_end(1'b0);

        // Letters with one dot after digit 2
        send_frame(32'hDEAD_BEEF, 8'b0000_0100);
        wait_frame_end(1'b0);

        // Dots on the first and the last digit
        send_frame(32'h9ABC_DEF0, 8'b1000_0001);
        wait_frame_end(1'b0);

        // txready stall between bytes 2 and 3
        base = n_strobes;
        send_frame(32'h0246_8ACE, 8'b0001_0000);
        wait_strobes(base + 2);
        @(posedge CLK); #1;
        txready = 1'b0;
        hold = txdata;
        repeat (5) begin
            @(negedge CLK);
            check("stall_no_strobe", {31'h0, txclk}, 32'd0);
            check("stall_txdata_held", {24'h0, txdata}, {24'h0, hold});
        end
        @(posedge CLK); #1;
        txready = 1'b1;
        wait_frame_end(1'b0);

        // send pulsed mid-frame and in the done cycle
        base = n_strobes;
        send_frame(32'h1357_9BDF, 8'b0100_0000);
        wait_strobes(base + 2);
        @(posedge CLK); #1;
        digits = 32'hFFFF_FFFF;
        flt_pt = 8'hFF;
        send   = 1'b1;
        @(posedge CLK); #1;
        send = 1'b0;
        wait_frame_end(1'b1);
        repeat (40) @(negedge CLK);
        check("no_extra_frame_busy", {31'h0, busy}, 32'd0);
        check("no_extra_frame_queue", exp_q.size(), 32'd0);

        // Inputs change during the frame; only the snapshot is sent
        send_frame(32'h8076_5A1C, 8'b0010_0010);
        repeat (10) begin
            @(posedge CLK); #1;
            digits = $urandom;
            flt_pt = 8'($urandom);
        end
        wait_frame_end(1'b0);

        // Reset after three strobes aborts the frame
        base = n_strobes;
        send_frame(32'h4444_5555, 8'h00);
        wait_strobes(base + 3);
        @(posedge CLK); #1;
        RST = 1'b1;
        #1;
        check("abort_txclk", {31'h0, txclk}, 32'd0);
        check("abort_busy", {31'h0, busy}, 32'd0);
        check("abort_txdata", {24'h0, txdata}, 32'h0);
        exp_q.delete();
        @(posedge CLK);
        @(posedge CLK); #1;
        RST = 1'b0;
        base = n_strobes;
        repeat (40) @(negedge CLK);
        check("abort_no_strobes", n_strobes, base);
        check("abort_idle", {31'h0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
